// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing one 8-digit seven-segment driver among four
// debug views, with dwell-timed or button-driven advance and a blank gap between sources.
module seg_disp_sched #(
    parameter int unsigned DWELL_CYC = 50000000,
    parameter int unsigned GAP_CYC   = 1000,
    parameter int unsigned DEB_CYC   = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         auto_en,
    input  logic         btn_next,
    input  logic [3:0]   src_req,
    input  logic [255:0] src_data,
    input  logic [3:0]   src_mode,
    output logic [63:0]  disp_data,
    output logic         disp_mode,
    output logic [1:0]   cur_src,
    output logic         disp_active,
    output logic [3:0]   src_grant
);
    localparam int DW_W = $clog2(DWELL_CYC + 1);
    localparam int GP_W = $clog2(GAP_CYC + 1);
    localparam int DB_W = $clog2(DEB_CYC + 1);
    localparam logic [63:0] BLANK = '1;

    typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

    state_t          state_q, state_d;
    logic [63:0]     disp_data_q, disp_data_d;
    logic            disp_mode_q, disp_mode_d;
    logic [1:0]      cur_src_q, cur_src_d;
    logic            disp_active_q, disp_active_d;
    logic [3:0]      src_grant_q, src_grant_d;
    logic [DW_W-1:0] dwell_q, dwell_d;
    logic [GP_W-1:0] gap_q, gap_d;
    logic            sync1_q, sync1_d, sync2_q, sync2_d;
    logic            deb_q, deb_d;
    logic [DB_W-1:0] deb_cnt_q, deb_cnt_d;
    logic            btn_pulse_q, btn_pulse_d;

    logic [63:0] cur_data;
    logic        cur_req, others, expire, adv;
    logic [1:0]  nxt;

    // First requester scanning p+1, p+2, p+3, p; returns p when nobody asks.
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] req);
        logic [1:0] idx;
        pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (req[idx]) pick = idx;
        end
    endfunction

    always_comb begin
        cur_data = src_data[{cur_src_q, 6'b0} +: 64];
        cur_req  = src_req[cur_src_q];
        others   = |(src_req & ~(4'b0001 << cur_src_q));
        expire   = (dwell_q == DW_W'(DWELL_CYC - 1));
        adv      = btn_pulse_q | (auto_en & expire);
        nxt      = pick(cur_src_q, src_req);

        state_d       = state_q;
        disp_data_d   = disp_data_q;
        disp_mode_d   = disp_mode_q;
        cur_src_d     = cur_src_q;
        disp_active_d = disp_active_q;
        src_grant_d   = '0;
        dwell_d       = dwell_q;
        gap_d         = gap_q;

        sync1_d     = btn_next;
        sync2_d     = sync1_q;
        deb_d       = deb_q;
        deb_cnt_d   = '0;
        btn_pulse_d = 1'b0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DB_W'(DEB_CYC - 1)) begin
                deb_d       = sync2_q;
                btn_pulse_d = sync2_q;
            end else begin
                deb_cnt_d = deb_cnt_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (|src_req) begin
                    state_d          = SHOW;
                    cur_src_d        = nxt;
                    src_grant_d[nxt] = 1'b1;
                    dwell_d          = '0;
                    disp_active_d    = 1'b1;
                end
            end
            SHOW: begin
                if (!cur_req || (adv && others)) begin
                    state_d       = GAP;
                    gap_d         = '0;
                    disp_active_d = 1'b0;
                    disp_data_d   = BLANK;
                    disp_mode_d   = 1'b1;
                end else begin
                    disp_data_d = cur_data;
                    disp_mode_d = src_mode[cur_src_q];
                    if (adv) begin
                        // Sole requester: refresh in place rather than blanking.
                        src_grant_d[cur_src_q] = 1'b1;
                        dwell_d                = '0;
                    end else if (!expire) begin
                        dwell_d = dwell_q + 1'b1;
                    end
                end
            end
            GAP: begin
                if (gap_q == GP_W'(GAP_CYC - 1)) begin
                    if (|src_req) begin
                        state_d          = SHOW;
                        cur_src_d        = nxt;
                        src_grant_d[nxt] = 1'b1;
                        dwell_d          = '0;
                        disp_active_d    = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            disp_data_q   <= BLANK;
            disp_mode_q   <= 1'b1;
            cur_src_q     <= 2'd3;
            disp_active_q <= 1'b0;
            src_grant_q   <= '0;
            dwell_q       <= '0;
            gap_q         <= '0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            deb_q         <= 1'b0;
            deb_cnt_q     <= '0;
            btn_pulse_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            disp_data_q   <= disp_data_d;
            disp_mode_q   <= disp_mode_d;
            cur_src_q     <= cur_src_d;
            disp_active_q <= disp_active_d;
            src_grant_q   <= src_grant_d;
            dwell_q       <= dwell_d;
            gap_q         <= gap_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            deb_q         <= deb_d;
            deb_cnt_q     <= deb_cnt_d;
            btn_pulse_q   <= btn_pulse_d;
        end
    end

    assign disp_data   = disp_data_q;
    assign disp_mode   = disp_mode_q;
    assign cur_src     = cur_src_q;
    assign disp_active = disp_active_q;
    assign src_grant   = src_grant_q;
endmodule

// File: doc/seg_disp_sched.md
Name: seg_disp_sched

Overview:
- Scheduler that shares the 8-digit seven-segment display driver among four requesters (e.g. PC, instruction, register-file and memory debug views).
- Each requester presents 64 bits of display data plus a mode bit (0 = hex, low 32 bits used; 1 = raw segment bytes).
- The block chooses one requester round-robin and feeds its data and mode to the display driver, switching sources when:
  - a dwell timer expires (auto mode),
  - a debounced push-button is pressed, or
  - the current source withdraws its request.
- A blank gap is inserted between sources to avoid ghosting.

Parameters:
- DWELL_CYC, 50000000: cycles a source is shown before auto-advance.
- GAP_CYC, 1000: blank cycles between sources, minimum 1.
- DEB_CYC, 1000000: cycles btn_next must be stable to register a level change.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- auto_en  in  1  1 = advance on dwell expiry; 0 = advance only on button or request drop
- btn_next  in  1  raw asynchronous push-button, active-high
- src_req  in  4  per-source display request, level
- src_data  in  256  packed source data; source i occupies [64i+63:64i]
- src_mode  in  4  per-source mode bit
- disp_data  out  64  to display driver data input
- disp_mode  out  1  to display driver mode input
- cur_src  out  2  index of source being shown
- disp_active  out  1  1 while in SHOW
- src_grant  out  4  one-hot, one-cycle pulse when a source is switched in

Behaviour:
- All outputs are registered.
- Reset is asynchronous and active-high. Reset values:
  - state = IDLE
  - disp_data = 64'hFFFF_FFFF_FFFF_FFFF and disp_mode = 1 (all segments off, i.e. blank)
  - cur_src = 3 (so source 0 has first priority)
  - disp_active = 0, src_grant = 0
  - dwell/gap/debounce counters = 0
- Reset mid-operation returns to these values immediately, regardless of state.
- Button conditioning:
  - 2-FF synchronizer on btn_next.
  - Debounced level updates only after the synchronized value differs from it for DEB_CYC consecutive cycles.
  - A debounced 0->1 transition produces a one-cycle btn_pulse.
  - Releases and bounces shorter than DEB_CYC are ignored.
- Arbitration function pick(p):
  - Returns the first requesting index scanning p+1, p+2, p+3, p (mod 4).
  - A request is valid only if it is asserted in the evaluating cycle.
- FSM states: IDLE, SHOW, GAP.
  - IDLE:
    - Outputs blank, disp_active = 0.
    - If |src_req: s = pick(cur_src). On that edge, cur_src <= s, src_grant[s] pulses for 1 cycle, and the dwell counter clears. Go to SHOW.
    - Latency: request sampled at edge k; data visible on disp_data after edge k+1.
  - SHOW:
    - disp_active = 1.
    - Every cycle, disp_data/disp_mode <= src_data/src_mode of cur_src (live tracking, 1-cycle latency).
    - The dwell counter increments every cycle.
    - adv = btn_pulse OR (auto_en AND dwell == DWELL_CYC-1).
    - If src_req[cur_src] == 0: go to GAP (takes priority over adv).
    - Else if adv:
      - If another source is requesting, go to GAP.
      - If cur_src is the only requester, stay in SHOW, clear dwell, and pulse src_grant[cur_src] again (refresh).
    - Simultaneous btn_pulse and dwell expiry cause exactly one advance.
    - If auto_en = 0, the dwell counter saturates at DWELL_CYC-1 and does not trigger advance.
  - GAP:
    - Outputs blank, disp_active = 0, gap counter runs 0..GAP_CYC-1.
    - btn_pulse is ignored in GAP.
    - At the last gap cycle:
      - If |src_req: s = pick(cur_src), load as in IDLE, go to SHOW.
      - Else go to IDLE (cur_src retained).
- Boundaries:
  - All requests drop during SHOW: GAP, then IDLE.
  - A request arriving during GAP is honoured at gap end.
  - Counters never wrap: dwell clears on every switch or refresh; gap clears on GAP entry.

Test Plan:
(DWELL_CYC=8, GAP_CYC=2, DEB_CYC=4)
1. Reset, src_req=0 -> disp_data=FFFF_FFFF_FFFF_FFFF, disp_mode=1, disp_active=0, src_grant=0. Assert rst mid-SHOW -> same values on the next sample, state IDLE.
2. Single request: src_req=0100, data2=0000_0000_1234_5678, mode2=0 ->
   - src_grant=0100 for 1 cycle, cur_src=2.
   - disp_data=...12345678 one cycle later.
   - With auto_en=1: refresh grant pulse every 8 cycles, no GAP.
   - Change data2 to 0000_0000_8765_4321 -> disp_data follows after 1 cycle.
3. Round-robin, auto_en=1, src_req=1011 from reset:
   - Grant order 0, 1, 3, 0.
   - Each source shown 8 cycles, separated by exactly 2 blank cycles.
4. auto_en=0, src_req=0011: source 0 held indefinitely. Then:
   - btn_next high 2 cycles -> no change.
   - btn_next high 10 cycles -> single switch to source 1 after synchronizer + 4-cycle debounce + gap.
5. Drop and simultaneous events:
   - Showing source 1, deassert src_req[1] -> GAP next cycle, then next requester, or IDLE if none.
   - Button pulse on dwell expiry cycle -> one advance only.
6. Request during GAP: src_req=0001, src_req[0] drops; assert src_req[3] in GAP cycle 0 -> source 3 granted at gap end, disp_mode=src_mode[3].
